mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port (IF) and data port (MEM).
// Sequences each access: arbitrate -> issue -> wait LATENCY -> respond, and drives per-port stall signals to the pipeline.
// Data has priority, because the MEM-stage instruction is older; a burst limit prevents fetch starvation.
// PARAMETERS
// LATENCY    2  cycles from the mem_en pulse until mem_rdata is valid; legal range 1..15
// MAX_DBURST 4  max consecutive data grants while if_req is pending; legal range 1..15
// PORTS
// clk        in   1   clock, rising edge
// reset      in   1   reset, asynchronous, active-high
// if_req     in   1   fetch request; held high, with if_addr stable, until if_valid
// if_addr    in   32  fetch byte address; must be word aligned
// if_valid   out  1   one-cycle pulse: if_rdata is valid
// if_rdata   out  32  fetched instruction, held until the next IF response
// d_req      in   1   data request; held high, with d_we/d_size/d_addr/d_wdata stable, until d_valid
// d_we       in   1   1 = store, 0 = load
// d_size     in   2   00 = byte, 01 = half, 10 = word, 11 = reserved
// d_addr     in   32  data byte address
// d_wdata    in   32  store data, passed to memory unchanged
// d_valid    out  1   one-cycle pulse: data access complete (d_rdata valid if load)
// d_err      out  1   pulses together with d_valid: access rejected (misaligned or reserved size)
// d_rdata    out  32  load data, held until the next data response
// stall_if   out  1   if_req & ~if_valid (combinational)
// stall_mem  out  1   d_req & ~d_valid (combinational)
// mem_en     out  1   one-cycle access strobe to memory
// mem_we     out  1   write enable, qualified by mem_en
// mem_size   out  2   access size, qualified by mem_en (IF always drives 10)
// mem_addr   out  32  address, qualified by mem_en
// mem_wdata  out  32  write data, qualified by mem_en
// mem_rdata  in   32  read data, sampled LATENCY cycles after mem_en
// BEHAVIOUR
// - Reset: FSM=IDLE, owner=none, burst counter=0. All outputs are 0, including both rdata registers.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE:
//   - no request -> stay in IDLE.
//   - otherwise pick a winner and register it as owner -> ISSUE.
// - Arbitration rules (evaluated in IDLE only):
//   - d_req alone -> D. if_req alone -> IF.
//   - both requests:
//     - D wins if dburst < MAX_DBURST; then dburst++.
//     - else IF wins.
//   - any IF grant clears dburst; a D grant with if_req low also clears dburst.
// - Data-access check, made at grant time:
//   - reject if d_size=11, or half with addr[0]=1, or word with addr[1:0]!=00.
//   - on reject: go to RESP with d_err=1; no mem_en is ever issued.
// - ISSUE:
//   - mem_en=1 for exactly one cycle with the owner's we/size/addr/wdata; load the latency counter with LATENCY.
//   - -> WAIT.
// - WAIT:
//   - decrement the counter each cycle.
//   - on the cycle the counter hits 0, capture mem_rdata into the owner's rdata register (only if load/fetch) -> RESP.
// - RESP:
//   - pulse owner's valid (and d_err if rejected) for 1 cycle -> IDLE.
//   - The new request is first seen in IDLE on the next cycle.
// - Latency, counting the cycle req is first seen in IDLE as cycle 0:
//   - mem_en in cycle 1; valid in cycle LATENCY+2.
//   - rejected access: d_valid in cycle 1.
// - Outside ISSUE: mem_en=0; mem_we/mem_size/mem_addr/mem_wdata=0.
// - Store: d_rdata is not updated; d_valid still pulses.
// - Requester drops req mid-transaction (protocol violation): the transaction still completes and valid still pulses.
// - Requests arriving during ISSUE/WAIT/RESP are not sampled until IDLE.
// - Reset mid-transaction: immediate return to IDLE; the in-flight response is discarded and no valid pulse occurs.
// - Counters are 4 bits wide. dburst saturates at MAX_DBURST and never wraps.
// TESTING
// 1. LATENCY=2. if_req at addr 0x40, mem returns 0xDEADBEEF -> mem_en cycle 1 with size 10; if_valid cycle 4 with rdata 0xDEADBEEF; stall_if high in cycles 0-3.
// 2. if_req and d_req (load word, addr 0x100) both rise in cycle 0 -> D is served first (d_valid cycle 4); IF mem_en in cycle 6; if_valid cycle 9.
// 3. MAX_DBURST=4. if_req held high, d_req re-raised every IDLE -> exactly 4 data grants, then 1 IF grant, then dburst restarts from 0.
// 4. d_size=01 at addr 0x103 -> d_valid & d_err in cycle 1; mem_en stays 0. d_size=11 at addr 0x0 -> same response.
// 5. Store byte, addr 0x7, wdata 0xA5 -> cycle 1: mem_en=1, mem_we=1, size 00, addr 0x7; d_valid cycle 4; d_rdata unchanged.
// 6. Assert reset during WAIT of a fetch -> all outputs 0 at once; no if_valid. A request after reset is served normally with full latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch (IF) and data (MEM) ports.
// Data wins contention because its instruction is older; a burst limit keeps fetch from starving.
module mem_port_arbiter #(
    parameter int LATENCY    = 2,
    parameter int MAX_DBURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] LAT_LOAD   = 4'(LATENCY);
    localparam logic [3:0] DBURST_MAX = 4'(MAX_DBURST);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  dburst_q, dburst_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        is_read_q, is_read_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_valid_q, d_valid_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic d_bad;
    logic d_wins;

    always_comb begin
        d_bad  = (d_size == 2'b11)
               | ((d_size == 2'b01) & d_addr[0])
               | ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));
        d_wins = d_req & (~if_req | (dburst_q < DBURST_MAX));
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        dburst_d    = dburst_q;
        lat_cnt_d   = lat_cnt_q;
        is_read_d   = is_read_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_size_d  = 2'b00;
        mem_addr_d  = 32'h0;
        mem_wdata_d = 32'h0;

        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    owner_d  = OWN_D;
                    // The burst only counts while fetch is actually being held off.
                    dburst_d = if_req ? dburst_q + 4'd1 : 4'd0;
                    if (d_bad) begin
                        state_d   = RESP;
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        is_read_d   = ~d_we;
                        mem_en_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_size_d  = d_size;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end
                end else if (if_req) begin
                    owner_d    = OWN_IF;
                    dburst_d   = 4'd0;
                    state_d    = ISSUE;
                    is_read_d  = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_size_d = 2'b10;
                    mem_addr_d = if_addr;
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d    = RESP;
                    if_valid_d = (owner_q == OWN_IF);
                    d_valid_d  = (owner_q == OWN_D);
                    if (is_read_q && owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end
                    if (is_read_q && owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            dburst_q    <= 4'd0;
            lat_cnt_q   <= 4'd0;
            is_read_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dburst_q    <= dburst_d;
            lat_cnt_q   <= lat_cnt_d;
            is_read_q   <= is_read_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory issues and responses are queued
// when stimulus is driven and popped by a monitor as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int LATENCY    = 2;
    localparam int MAX_DBURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_d_rdata = 32'h0;

    typedef struct {
        bit          is_d;
        int          cycle;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    typedef struct {
        int          cycle;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    resp_t  resp_q[$];
    issue_t issue_q[$];

    mem_port_arbiter #(.LATENCY(LATENCY), .MAX_DBURST(MAX_DBURST)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is a fixed function of address (0x40 -> 0xDEADBEEF), and is only
    // driven in the single cycle LATENCY cycles after mem_en, so off-by-one captures show up.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'hDEADBEAF;
    endfunction

    bit   [15:0] en_pipe = '0;
    logic [31:0] addr_pipe [0:15];

    always @(posedge clk) begin
        en_pipe <= {en_pipe[14:0], mem_en};
        addr_pipe[0] <= mem_addr;
        for (int i = 1; i < 16; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    assign mem_rdata = en_pipe[LATENCY-1] ? mem_model(addr_pipe[LATENCY-1]) : 32'h0;

    function automatic void push_issue(input int c, input logic we, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
        issue_t it;
        it.cycle = c; it.we = we; it.size = sz; it.addr = a; it.wdata = wd;
        issue_q.push_back(it);
    endfunction

    function automatic void push_resp(input bit is_d, input int c, input logic [31:0] rd, input bit err);
        resp_t r;
        r.is_d = is_d; r.cycle = c; r.rdata = rd; r.err = err;
        resp_q.push_back(r);
    endfunction

    // Monitor: pops expectations as the DUT issues memory strobes and response pulses.
    always @(negedge clk) begin
        issue_t      ei;
        resp_t       er;
        logic [31:0] got_rd;
        if (!reset) begin
            checks++;
            if (mem_en) begin
                if (issue_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL mem_issue: unexpected mem_en at cycle %0d addr %h", cyc, mem_addr);
                end else begin
                    ei = issue_q.pop_front();
                    if (cyc !== ei.cycle || mem_we !== ei.we || mem_size !== ei.size ||
                        mem_addr !== ei.addr || mem_wdata !== ei.wdata) begin
                        errors++;
                        $display("[TB] FAIL mem_issue: got cyc %0d we %b size %b addr %h wdata %h, expected cyc %0d we %b size %b addr %h wdata %h",
                                 cyc, mem_we, mem_size, mem_addr, mem_wdata,
                                 ei.cycle, ei.we, ei.size, ei.addr, ei.wdata);
                    end
                end
            end else if ({mem_we, mem_size, mem_addr, mem_wdata} !== 67'd0) begin
                errors++;
                $display("[TB] FAIL mem_idle: got we %b size %b addr %h wdata %h, expected all 0 at cycle %0d",
                         mem_we, mem_size, mem_addr, mem_wdata, cyc);
            end

            checks++;
            if (if_valid || d_valid) begin
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL resp: unexpected if_valid %b d_valid %b at cycle %0d", if_valid, d_valid, cyc);
                end else begin
                    er = resp_q.pop_front();
                    got_rd = er.is_d ? d_rdata : if_rdata;
                    if (d_valid !== er.is_d || if_valid !== !er.is_d || cyc !== er.cycle ||
                        d_err !== er.err || got_rd !== er.rdata) begin
                        errors++;
                        $display("[TB] FAIL resp: got d_valid %b if_valid %b cyc %0d err %b rdata %h, expected d %b cyc %0d err %b rdata %h",
                                 d_valid, if_valid, cyc, d_err, got_rd, er.is_d, er.cycle, er.err, er.rdata);
                    end
                end
            end else if (d_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL d_err_idle: got %b expected 0 at cycle %0d", d_err, cyc);
            end
        end
    end

    // Bounded wait for the scoreboard to drain; drops each request once its response appears.
    task automatic wait_done(input int budget);
        int n = 0;
        while ((resp_q.size() > 0 || issue_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (if_valid) if_req = 1'b0;
            if (d_valid)  d_req  = 1'b0;
        end
        checks++;
        if (resp_q.size() > 0 || issue_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL timeout: got %0d responses and %0d issues outstanding, expected 0",
                     resp_q.size(), issue_q.size());
            resp_q.delete();
            issue_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({if_valid, d_valid, d_err, mem_en, mem_we, mem_size, stall_if, stall_mem} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {if_valid, d_valid, d_err, mem_en, mem_we, mem_size, stall_if, stall_mem});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got if %h d %h expected 0", if_rdata, d_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        int t0;
        @(negedge clk);
        if_addr = 32'h40;
        if_req  = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b0, 2'b10, 32'h40, 32'h0);
        push_resp(1'b0, t0 + LATENCY + 2, 32'hDEADBEEF, 1'b0);
        #1;
        for (int k = 0; k < LATENCY + 2; k++) begin
            checks++;
            if (stall_if !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_if_busy: cycle %0d got %b expected 1", k, stall_if);
            end
            @(negedge clk);
        end
        checks++;
        if (if_valid !== 1'b1 || stall_if !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_done: got if_valid %b stall_if %b expected 1 0", if_valid, stall_if);
        end
        if_req = 1'b0;
        wait_done(20);
        @(negedge clk);
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL if_rdata_hold: got %h expected deadbeef", if_rdata);
        end
    endtask

    task automatic test_priority();
        int t0;
        @(negedge clk);
        if_addr = 32'h200;
        if_req  = 1'b1;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h100; d_wdata = 32'h0;
        d_req = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b0, 2'b10, 32'h100, 32'h0);
        push_resp(1'b1, t0 + LATENCY + 2, mem_model(32'h100), 1'b0);
        push_issue(t0 + LATENCY + 4, 1'b0, 2'b10, 32'h200, 32'h0);
        push_resp(1'b0, t0 + 2 * LATENCY + 5, mem_model(32'h200), 1'b0);
        last_d_rdata = mem_model(32'h100);
        #1;
        checks++;
        if (stall_mem !== 1'b1 || stall_if !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_both: got mem %b if %b expected 1 1", stall_mem, stall_if);
        end
        wait_done(40);
    endtask

    task automatic test_burst();
        int t0;
        int dj = 0;
        int ij = 0;
        int n  = 0;
        int slot;
        @(negedge clk);
        if_addr = 32'h300;
        if_req  = 1'b1;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h400;
        d_req = 1'b1;
        t0 = cyc;
        slot = 0;
        for (int s = 0; s < 2 * (MAX_DBURST + 1); s++) begin
            int st;
            st = t0 + s * (LATENCY + 3);
            if ((s % (MAX_DBURST + 1)) == MAX_DBURST) begin
                push_issue(st + 1, 1'b0, 2'b10, 32'h300 + 32'(4 * (s / (MAX_DBURST + 1))), 32'h0);
                push_resp(1'b0, st + LATENCY + 2, mem_model(32'h300 + 32'(4 * (s / (MAX_DBURST + 1)))), 1'b0);
            end else begin
                push_issue(st + 1, 1'b0, 2'b10, 32'h400 + 32'(4 * slot), 32'h0);
                push_resp(1'b1, st + LATENCY + 2, mem_model(32'h400 + 32'(4 * slot)), 1'b0);
                last_d_rdata = mem_model(32'h400 + 32'(4 * slot));
                slot++;
            end
        end
        while (resp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (d_valid) begin
                dj++;
                d_addr = 32'h400 + 32'(4 * dj);
            end
            if (if_valid) begin
                ij++;
                if_addr = 32'h300 + 32'(4 * ij);
                if (ij == 2) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        checks++;
        if (dj !== 2 * MAX_DBURST || ij !== 2) begin
            errors++;
            $display("[TB] FAIL burst_count: got %0d data %0d fetch grants, expected %0d and 2", dj, ij, 2 * MAX_DBURST);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        wait_done(20);
    endtask

    task automatic test_reject();
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        int t0;
        sizes[0] = 2'b01; addrs[0] = 32'h103;
        sizes[1] = 2'b11; addrs[1] = 32'h0;
        sizes[2] = 2'b10; addrs[2] = 32'h2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_we = 1'b0; d_size = sizes[i]; d_addr = addrs[i]; d_wdata = 32'h0;
            d_req = 1'b1;
            t0 = cyc;
            push_resp(1'b1, t0 + 1, last_d_rdata, 1'b1);
            @(negedge clk);
            checks++;
            if (d_valid !== 1'b1 || d_err !== 1'b1 || mem_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reject_%0d: got d_valid %b d_err %b mem_en %b expected 1 1 0",
                         i, d_valid, d_err, mem_en);
            end
            d_req = 1'b0;
            wait_done(10);
        end
    endtask

    task automatic test_store();
        int t0;
        @(negedge clk);
        d_we = 1'b1; d_size = 2'b00; d_addr = 32'h7; d_wdata = 32'hA5;
        d_req = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b1, 2'b00, 32'h7, 32'hA5);
        push_resp(1'b1, t0 + LATENCY + 2, last_d_rdata, 1'b0);
        wait_done(20);
        @(negedge clk);
        d_we = 1'b0; d_size = 2'b01; d_addr = 32'h102; d_wdata = 32'h0;
        d_req = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b0, 2'b01, 32'h102, 32'h0);
        push_resp(1'b1, t0 + LATENCY + 2, mem_model(32'h102), 1'b0);
        last_d_rdata = mem_model(32'h102);
        wait_done(20);
    endtask

    task automatic test_reset_mid();
        int t0;
        @(negedge clk);
        if_addr = 32'h80;
        if_req  = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b0, 2'b10, 32'h80, 32'h0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        if_req = 1'b0;
        #1;
        checks++;
        if ({if_valid, d_valid, d_err, mem_en, mem_we, mem_size, stall_if, stall_mem} !== 9'd0 ||
            {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got ctrl %b addr %h if_rdata %h d_rdata %h expected 0",
                     {if_valid, d_valid, d_err, mem_en, mem_we, mem_size, stall_if, stall_mem},
                     mem_addr, if_rdata, d_rdata);
        end
        last_d_rdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (if_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_discard: got if_rdata %h expected 0", if_rdata);
        end
        if_addr = 32'h84;
        if_req  = 1'b1;
        t0 = cyc;
        push_issue(t0 + 1, 1'b0, 2'b10, 32'h84, 32'h0);
        push_resp(1'b0, t0 + LATENCY + 2, mem_model(32'h84), 1'b0);
        wait_done(20);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_priority();
        test_burst();
        test_reject();
        test_store();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
